// File: rtl/mem_write_checker.sv
// rtl/mem_write_checker.sv - shadow-memory write capture and golden-array checker
//
// Purpose:
//   Snoops core data-memory writes into a shadow memory until the write to
//   END_ADDR arrives (or the capture-cycle limit expires). It then walks the
//   checked window shadow[ARR_BEGIN +: ARR_LEN] against a combinational golden
//   ROM, one word per cycle, and holds a final report until reset.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   addr       in   [ADDR_W] core write word address
//   data       in   [DATA_W] core write data
//   wen        in   write strobe qualifying addr/data
//   gold_idx   out  [16] golden ROM index (k during check, else 0)
//   gold_data  in   [DATA_W] golden word for gold_idx, same cycle
//   error_num  out  [8] mismatch count, saturating
//   duration   out  [16] capture cycle count, saturating
//   first_err  out  [16] index of first mismatch, 0xFFFF if none
//   finish     out  report reached
//   pass       out  report reached with no errors, no timeout, no oob
//   timeout    out  capture ended by the cycle limit
//   oob        out  a write beyond the shadow memory was seen (sticky)

module mem_write_checker #(
  parameter int ADDR_W    = 30,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 256,
  parameter int ARR_BEGIN = 128,
  parameter int ARR_LEN   = 8,
  parameter int END_ADDR  = 255,
  parameter int TIMEOUT   = 65535,
  parameter int SWAP      = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              wen,
  output logic [15:0]       gold_idx,
  input  logic [DATA_W-1:0] gold_data,
  output logic [7:0]        error_num,
  output logic [15:0]       duration,
  output logic [15:0]       first_err,
  output logic              finish,
  output logic              pass,
  output logic              timeout,
  output logic              oob
);

  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NBYTES = DATA_W / 8;

  typedef enum logic [1:0] {
    S_CAPTURE,
    S_CHECK,
    S_REPORT
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [DATA_W-1:0] r_shadow [DEPTH];
  logic [15:0]       r_k;
  logic [7:0]        r_err;
  logic [15:0]       r_duration;
  logic [15:0]       r_first;
  logic              r_timeout;
  logic              r_oob;

  logic [DATA_W-1:0] w_wdata;
  logic              w_wr_in_range;
  logic [IDX_W-1:0]  w_wr_idx;
  logic              w_end_wr;
  logic              w_dur_last;
  logic              w_chk_active;
  logic              w_settled;
  logic [IDX_W-1:0]  w_rd_idx;
  logic [DATA_W-1:0] w_rd_word;
  logic              w_mismatch;

  // Incoming core data is little-endian; reversing bytes makes the shadow
  // words read naturally against the golden ROM.
  always_comb begin
    w_wdata = data;
    if (SWAP != 0) begin
      for (int b = 0; b < NBYTES; b++) begin
        w_wdata[8*b +: 8] = data[8*(NBYTES-1-b) +: 8];
      end
    end
  end

  assign w_wr_in_range = (addr < ADDR_W'(DEPTH));
  assign w_wr_idx      = IDX_W'(addr);
  assign w_end_wr      = wen && (addr == ADDR_W'(END_ADDR));
  assign w_dur_last    = (32'(r_duration) == 32'(TIMEOUT - 1));

  // k runs 0..ARR_LEN-1 comparing; the extra cycle at k==ARR_LEN lets the last
  // comparison settle into error_num/first_err before the report is raised.
  assign w_chk_active  = (r_state == S_CHECK) && (32'(r_k) < 32'(ARR_LEN));
  assign w_settled     = (r_state == S_CHECK) && (32'(r_k) >= 32'(ARR_LEN));
  assign w_rd_idx      = w_chk_active ? IDX_W'(ARR_BEGIN + int'(r_k)) : IDX_W'(ARR_BEGIN);
  assign w_rd_word     = r_shadow[w_rd_idx];
  assign w_mismatch    = w_chk_active && (w_rd_word != gold_data);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_CAPTURE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_CAPTURE: begin
        // The END_ADDR write wins over an expiring limit in the same cycle.
        if (w_end_wr) begin
          w_state_nxt = S_CHECK;
        end else if (w_dur_last) begin
          w_state_nxt = S_REPORT;
        end
      end
      S_CHECK: begin
        if (w_settled) begin
          w_state_nxt = S_REPORT;
        end
      end
      S_REPORT: begin
        w_state_nxt = S_REPORT;
      end
      default: begin
        w_state_nxt = S_CAPTURE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_shadow[i] <= '0;
      end
      r_k        <= '0;
      r_err      <= '0;
      r_duration <= '0;
      r_first    <= 16'hFFFF;
      r_timeout  <= 1'b0;
      r_oob      <= 1'b0;
    end else begin
      unique case (r_state)
        S_CAPTURE: begin
          r_k <= '0;
          if (r_duration != 16'hFFFF) begin
            r_duration <= r_duration + 16'd1;
          end
          if (wen) begin
            if (w_wr_in_range) begin
              r_shadow[w_wr_idx] <= w_wdata;
            end else begin
              r_oob <= 1'b1;
            end
          end
          if (!w_end_wr && w_dur_last) begin
            r_timeout <= 1'b1;
          end
        end
        S_CHECK: begin
          if (w_chk_active) begin
            r_k <= r_k + 16'd1;
          end
          if (w_mismatch) begin
            if (r_err != 8'hFF) begin
              r_err <= r_err + 8'd1;
            end
            if (r_first == 16'hFFFF) begin
              r_first <= r_k;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign gold_idx  = w_chk_active ? r_k : 16'd0;
  assign error_num = r_err;
  assign duration  = r_duration;
  assign first_err = r_first;
  assign finish    = (r_state == S_REPORT);
  assign pass      = finish && (r_err == 8'd0) && !r_timeout && !r_oob;
  assign timeout   = r_timeout;
  assign oob       = r_oob;

endmodule

// File: tb/tb_mem_write_checker.sv
// tb/tb_mem_write_checker.sv - self-checking bench for mem_write_checker

module tb_mem_write_checker;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst  = 1'b0;
  logic        wen  = 1'b0;
  logic [29:0] addr = '0;
  logic [31:0] data = '0;

  logic [15:0] gold_idx;
  logic [31:0] gold_data;
  logic [7:0]  error_num;
  logic [15:0] duration;
  logic [15:0] first_err;
  logic        finish, pass, timeout, oob;

  logic        wen_t  = 1'b0;
  logic [29:0] addr_t = '0;
  logic [31:0] data_t = '0;
  logic [31:0] gold_data_t = '0;
  logic [15:0] gold_idx_t;
  logic [7:0]  error_num_t;
  logic [15:0] duration_t;
  logic [15:0] first_err_t;
  logic        finish_t, pass_t, timeout_t, oob_t;

  logic [31:0] rom [8];
  assign gold_data = (gold_idx < 16'd8) ? rom[gold_idx[2:0]] : 32'h0;

  mem_write_checker dut (
    .clk(clk), .rst(rst), .addr(addr), .data(data), .wen(wen),
    .gold_idx(gold_idx), .gold_data(gold_data), .error_num(error_num),
    .duration(duration), .first_err(first_err), .finish(finish),
    .pass(pass), .timeout(timeout), .oob(oob)
  );

  mem_write_checker #(.TIMEOUT(20)) dut_t (
    .clk(clk), .rst(rst), .addr(addr_t), .data(data_t), .wen(wen_t),
    .gold_idx(gold_idx_t), .gold_data(gold_data_t), .error_num(error_num_t),
    .duration(duration_t), .first_err(first_err_t), .finish(finish_t),
    .pass(pass_t), .timeout(timeout_t), .oob(oob_t)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: time since the end write and the captured shadow
  // contents determine every expected output.
  logic [31:0] m_shadow [256];
  int          m_dur   = 0;
  int          m_n     = 0;
  int          m_t_dur = 0;
  bit          m_end   = 1'b0;
  bit          m_oob   = 1'b0;
  bit          m_valid = 1'b0;

  function automatic logic [31:0] bswap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  task automatic model_update(input logic r, input logic w, input logic [29:0] a, input logic [31:0] d);
    if (r) begin
      for (int i = 0; i < 256; i++) m_shadow[i] = 32'h0;
      m_dur = 0; m_n = 0; m_end = 1'b0; m_oob = 1'b0; m_t_dur = 0;
      m_valid = 1'b1;
    end else begin
      if (!m_end) begin
        m_dur++;
        if (w) begin
          if (a < 30'd256) m_shadow[a[7:0]] = bswap(d);
          else m_oob = 1'b1;
          if (a == 30'd255) begin
            m_end = 1'b1;
            m_n = 0;
          end
        end
      end else if (m_n < 1000) begin
        m_n++;
      end
      if (m_t_dur < 20) m_t_dur++;
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      int e_done, e_err, e_first, e_idx;
      bit e_fin, e_pass;
      e_done  = m_end ? ((m_n < 8) ? m_n : 8) : 0;
      e_err   = 0;
      e_first = 16'hFFFF;
      for (int j = 0; j < e_done; j++) begin
        if (m_shadow[128 + j] != rom[j]) begin
          e_err++;
          if (e_first == 16'hFFFF) e_first = j;
        end
      end
      e_idx  = (m_end && m_n < 8) ? m_n : 0;
      e_fin  = m_end && (m_n >= 9);
      e_pass = e_fin && (e_err == 0) && !m_oob;
      chk("gold_idx",  32'(gold_idx),  32'(e_idx));
      chk("error_num", 32'(error_num), 32'(e_err));
      chk("first_err", 32'(first_err), 32'(e_first));
      chk("duration",  32'(duration),  32'(m_dur));
      chk("finish",    32'(finish),    32'(e_fin));
      chk("pass",      32'(pass),      32'(e_pass));
      chk("timeout",   32'(timeout),   32'(0));
      chk("oob",       32'(oob),       32'(m_oob));
      chk("t_finish",    32'(finish_t),    32'(m_t_dur >= 20));
      chk("t_timeout",   32'(timeout_t),   32'(m_t_dur >= 20));
      chk("t_duration",  32'(duration_t),  32'(m_t_dur));
      chk("t_pass",      32'(pass_t),      32'(0));
      chk("t_error_num", 32'(error_num_t), 32'(0));
      chk("t_first_err", 32'(first_err_t), 32'(16'hFFFF));
      chk("t_gold_idx",  32'(gold_idx_t),  32'(0));
      chk("t_oob",       32'(oob_t),       32'(0));
    end
  end

  task automatic tick(input logic r, input logic w, input logic [29:0] a, input logic [31:0] d);
    rst = r; wen = w; addr = a; data = d;
    @(posedge clk);
    model_update(r, w, a, d);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0, 30'd0, 32'h0);
  endtask

  task automatic write_array(input int bad0, input int bad1);
    for (int i = 0; i < 8; i++) begin
      logic [31:0] w;
      w = (i + 1) << 24;
      if (i == bad0 || i == bad1) w = 32'h5A000000 | w;
      tick(1'b0, 1'b1, 30'(128 + i), w);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rom[i] = 32'(i + 1);

    // Correct run
    tick(1'b1, 1'b0, 30'd0, 32'h0);
    tick(1'b1, 1'b0, 30'd0, 32'h0);
    chk("lit_rst_first_err", 32'(first_err), 32'h0000FFFF);
    chk("lit_rst_duration",  32'(duration),  32'd0);
    chk("lit_rst_finish",    32'(finish),    32'd0);
    write_array(-1, -1);
    tick(1'b0, 1'b1, 30'd255, 32'hDEADBEEF);
    idle(8);
    chk("lit_finish_at_8", 32'(finish), 32'd0);
    idle(1);
    chk("lit_finish_at_9", 32'(finish), 32'd1);
    chk("lit_pass",        32'(pass),   32'd1);
    chk("lit_err0",        32'(error_num), 32'd0);
    chk("lit_first_none",  32'(first_err), 32'h0000FFFF);
    chk("lit_duration9",   32'(duration),  32'd9);
    // Writes during report are ignored
    tick(1'b0, 1'b1, 30'd130, 32'h11223344);
    tick(1'b0, 1'b1, 30'd255, 32'h55667788);
    idle(2);
    chk("lit_rep_err",  32'(error_num), 32'd0);
    chk("lit_rep_dur",  32'(duration),  32'd9);
    chk("lit_rep_pass", 32'(pass),      32'd1);

    // Corrupted words at 130 and 133
    tick(1'b1, 1'b0, 30'd0, 32'h0);
    write_array(2, 5);
    tick(1'b0, 1'b1, 30'd255, 32'h0);
    idle(10);
    chk("lit_bad_err",   32'(error_num), 32'd2);
    chk("lit_bad_first", 32'(first_err), 32'd2);
    chk("lit_bad_pass",  32'(pass),      32'd0);
    chk("lit_bad_fin",   32'(finish),    32'd1);

    // Capture limit on the TIMEOUT=20 instance
    tick(1'b1, 1'b0, 30'd0, 32'h0);
    idle(19);
    chk("lit_to_fin19", 32'(finish_t), 32'd0);
    idle(1);
    chk("lit_to_fin20", 32'(finish_t), 32'd1);
    idle(5);
    chk("lit_to_timeout", 32'(timeout_t),   32'd1);
    chk("lit_to_pass",    32'(pass_t),      32'd0);
    chk("lit_to_err",     32'(error_num_t), 32'd0);
    chk("lit_to_dur",     32'(duration_t),  32'd20);

    // Out-of-range write then a correct array
    tick(1'b1, 1'b0, 30'd0, 32'h0);
    tick(1'b0, 1'b1, 30'd300, 32'h12345678);
    write_array(-1, -1);
    tick(1'b0, 1'b1, 30'd255, 32'h0);
    idle(10);
    chk("lit_oob",      32'(oob),       32'd1);
    chk("lit_oob_err",  32'(error_num), 32'd0);
    chk("lit_oob_pass", 32'(pass),      32'd0);
    chk("lit_oob_fin",  32'(finish),    32'd1);

    // Reset in the middle of the check walk, together with an end write
    tick(1'b1, 1'b0, 30'd0, 32'h0);
    write_array(1, -1);
    tick(1'b0, 1'b1, 30'd255, 32'h0);
    idle(3);
    chk("lit_k3_idx", 32'(gold_idx), 32'd3);
    tick(1'b1, 1'b1, 30'd255, 32'h0);
    chk("lit_mid_idx",   32'(gold_idx),  32'd0);
    chk("lit_mid_err",   32'(error_num), 32'd0);
    chk("lit_mid_first", 32'(first_err), 32'h0000FFFF);
    chk("lit_mid_dur",   32'(duration),  32'd0);
    chk("lit_mid_fin",   32'(finish),    32'd0);
    idle(3);
    chk("lit_lost_end", 32'(finish), 32'd0);
    write_array(-1, -1);
    tick(1'b0, 1'b1, 30'd255, 32'h0);
    idle(10);
    chk("lit_fresh_pass", 32'(pass), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
